fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, and fills the IF/ID register read by the decoder.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/fetch_stage.sv | 179 +++++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: XLEN, default reset PC and NOP encoding,
// fetch FSM state encoding, and the IF/ID pipeline register layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ  = 2'd1;
  localparam logic [1:0] FETCH_WAIT = 2'd2;
  localparam logic [1:0] FETCH_DROP = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches a memory response
// arriving while decode is stalled.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clr_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            full_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            full_q, full_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments; the payload is reset too so a
  // single-entry buffer never exposes X to the decoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble performance counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_id_valid_o,
  output logic [XLEN-1:0] if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_bubble_o,
`endif
  output logic            misalign_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            misalign_q, misalign_d;
  if_id_t          if_id_q, if_id_d;

  logic            flush;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            accept_rv;
  logic            skid_full, skid_push, skid_pop;
  logic [XLEN-1:0] skid_instr, skid_pc;

  assign flush     = trap_i | redirect_i;
  assign target    = trap_i ? trap_vec_i : redirect_pc_i;
  assign fire      = imem_req_o & imem_gnt_i;
  assign accept_rv = imem_rvalid_i && (state_q == FETCH_WAIT);

  // A WAIT-state response frees the port, so the next request can go out in
  // the same cycle unless that response is being squashed.
  always_comb begin
    imem_req_o = 1'b0;
    if (!stall_i && !skid_full) begin
      if (state_q == FETCH_REQ) begin
        imem_req_o = 1'b1;
      end else if (state_q == FETCH_WAIT && imem_rvalid_i && !flush) begin
        imem_req_o = 1'b1;
      end
    end
  end
  assign imem_addr_o = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    misalign_d = 1'b0;

    if (fire) begin
      req_pc_d = pc_q;
    end

    if (flush) begin
      pc_d       = word_align(target);
      misalign_d = (target[1:0] != 2'b00);
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end

    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        if (fire) state_d = flush ? FETCH_DROP : FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) state_d = fire ? FETCH_WAIT : FETCH_REQ;
        else if (flush)    state_d = FETCH_DROP;
      end
      FETCH_DROP: begin
        if (imem_rvalid_i) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // IF/ID priority: squash, then stall (catch response in skid), then skid
  // drain ahead of fresh memory data, else bubble.
  always_comb begin
    if_id_d   = if_id_q;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    if (flush) begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end else if (stall_i) begin
      skid_push = accept_rv;
    end else if (skid_full) begin
      if_id_d  = '{valid: 1'b1, instr: skid_instr, pc: skid_pc};
      skid_pop = 1'b1;
    end else if (accept_rv) begin
      if_id_d = '{valid: 1'b1, instr: imem_rdata_i, pc: req_pc_q};
    end else begin
      if_id_d.valid = 1'b0;
      if_id_d.instr = NOP_INSTR;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clr_i   (flush),
    .instr_i (imem_rdata_i),
    .pc_i    (req_pc_q),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      misalign_q <= 1'b0;
      if_id_q    <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      misalign_q <= misalign_d;
      if_id_q    <= if_id_d;
    end
  end

  assign if_id_valid_o = if_id_q.valid;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_pc4_o   = if_id_q.pc + 32'd4;
  assign misalign_o    = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (!flush && !stall_i && (skid_full || accept_rv)) perf_fetch_d = perf_fetch_q + 32'd1;
    if (!if_id_q.valid) perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a tiny instruction-memory model whose
// response data is 0xA000_0000 | address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, redirect_i, trap_i;
  logic [31:0] redirect_pc_i, trap_vec_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        if_id_valid_o, misalign_o;
  logic [31:0] if_id_instr_o, if_id_pc_o, if_id_pc4_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o, perf_bubble_o;
`endif

  int checks = 0;
  int errors = 0;

  int          mem_lat;
  int          cnt;
  logic        pend;
  logic [31:0] paddr;
  logic        inj_rv;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .trap_vec_i    (trap_vec_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_o  (perf_fetch_o),
    .perf_bubble_o (perf_bubble_o),
`endif
    .misalign_o    (misalign_o)
  );

  // Memory grants immediately and answers mem_lat cycles after the grant.
  assign imem_gnt_i    = imem_req_o;
  assign imem_rvalid_i = (pend && cnt == 0) || inj_rv;
  assign imem_rdata_i  = inj_rv ? 32'hDEAD_BEEF : (32'hA000_0000 | paddr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      cnt   <= 0;
      paddr <= '0;
    end else if (imem_req_o && imem_gnt_i) begin
      pend  <= 1'b1;
      paddr <= imem_addr_o;
      cnt   <= mem_lat - 1;
    end else if (imem_rvalid_i) begin
      pend <= 1'b0;
    end else if (pend && cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expected);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expected);
    checks++;
    assert (obs === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc);
    check_bit({tag, "_valid"}, if_id_valid_o, 1'b1);
    check({tag, "_pc"}, if_id_pc_o, pc);
    check({tag, "_instr"}, if_id_instr_o, 32'hA000_0000 | pc);
    check({tag, "_pc4"}, if_id_pc4_o, pc + 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    trap_i = 1'b0;
    redirect_pc_i = '0;
    trap_vec_i = '0;
    inj_rv = 1'b0;
    mem_lat = 1;

    repeat (2) @(posedge clk);
    #2;
    check_bit("rst_req", imem_req_o, 1'b0);
    check_bit("rst_valid", if_id_valid_o, 1'b0);
    check("rst_instr", if_id_instr_o, 32'h0000_0013);
    check("rst_pc", if_id_pc_o, 32'h0);
    check("rst_pc4", if_id_pc4_o, 32'h4);
    check_bit("rst_misalign", misalign_o, 1'b0);

    // Test 1: streaming fetch with a one-cycle memory
    rst_n = 1'b1;
    tick();
    check_bit("t1_req0", imem_req_o, 1'b1);
    check("t1_addr0", imem_addr_o, 32'h0);
    check_bit("t1_valid_c1", if_id_valid_o, 1'b0);
    tick();
    check("t1_addr4", imem_addr_o, 32'h4);
    check_bit("t1_valid_c2", if_id_valid_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_ifid("t1_stream", 32'(4 * k));
      check("t1_addr", imem_addr_o, 32'(4 * k + 8));
    end

    // Test 2: redirect while waiting for a slower response
    mem_lat = 2;
    tick();
    check("t2_pre_pc", if_id_pc_o, 32'h10);
    check_bit("t2_wait_noreq", imem_req_o, 1'b0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    check_bit("t2_bubble_valid", if_id_valid_o, 1'b0);
    check("t2_bubble_instr", if_id_instr_o, 32'h0000_0013);
    check_bit("t2_drop_noreq", imem_req_o, 1'b0);
    tick();
    mem_lat = 1;
    check_bit("t2_discard_valid", if_id_valid_o, 1'b0);
    check_bit("t2_req", imem_req_o, 1'b1);
    check("t2_addr", imem_addr_o, 32'h100);
    tick();
    tick();
    check_ifid("t2_target", 32'h100);

    // Test 3: trap wins over simultaneous redirect
    trap_i = 1'b1;
    trap_vec_i = 32'h200;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    trap_i = 1'b0;
    redirect_i = 1'b0;
    check("t3_addr", imem_addr_o, 32'h200);
    check_bit("t3_valid", if_id_valid_o, 1'b0);
    tick();
    tick();
    check_ifid("t3_trap", 32'h200);

    // Test 4: three-cycle stall with the response landing in the first
    stall_i = 1'b1;
    #1;
    check_bit("t4_stall_noreq", imem_req_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid("t4_frozen", 32'h200);
    end
    stall_i = 1'b0;
    #1;
    check_bit("t4_skid_noreq", imem_req_o, 1'b0);
    tick();
    check_ifid("t4_skid", 32'h204);
    check("t4_next_addr", imem_addr_o, 32'h208);
    tick();
    tick();
    check_ifid("t4_after", 32'h208);

    // Test 5: misaligned redirect target
    redirect_i = 1'b1;
    redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    check_bit("t5_misalign", misalign_o, 1'b1);
    check("t5_addr", imem_addr_o, 32'h100);
    tick();
    check_bit("t5_misalign_clr", misalign_o, 1'b0);
    tick();
    check_ifid("t5_target", 32'h100);

    // Test 6: reset mid-request, late response after release is ignored
    mem_lat = 3;
    tick();
    check_bit("t6_wait_noreq", imem_req_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check_bit("t6_rst_req", imem_req_o, 1'b0);
    check_bit("t6_rst_valid", if_id_valid_o, 1'b0);
    check("t6_rst_instr", if_id_instr_o, 32'h0000_0013);
    check("t6_rst_addr", imem_addr_o, 32'h0);
    tick();
    rst_n = 1'b1;
    inj_rv = 1'b1;
    mem_lat = 1;
    tick();
    inj_rv = 1'b0;
    check_bit("t6_late_valid", if_id_valid_o, 1'b0);
    check("t6_late_instr", if_id_instr_o, 32'h0000_0013);
    check_bit("t6_req", imem_req_o, 1'b1);
    check("t6_addr", imem_addr_o, 32'h0);
    tick();
    check_bit("t6_wait_valid", if_id_valid_o, 1'b0);
    tick();
    check_ifid("t6_first", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
